// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register carrying PC, instruction and payload,
// with flush/stall/nop control, optional skid entry and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int                 DATA_W    = 64,
    parameter int                 PC_W      = 64,
    parameter int                 INSTR_W   = 32,
    parameter int                 SKID      = 0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 'h0000_0013,
    parameter int                 CNT_W     = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               stall,
    input  logic               nop,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [DATA_W-1:0]  out_data,
    output logic [CNT_W-1:0]   bubble_cnt
);

    // state   | meaning
    // S_EMPTY | no beat held
    // S_ONE   | main entry holds the oldest beat
    // S_FULL  | main plus skid hold two beats (SKID=1 only), upstream blocked
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0]   main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
    logic [DATA_W-1:0]    main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CNT_W-1:0]     bub_q, bub_d;
    logic                 rdy_en_q;
    logic                 skid_valid, can_take, in_fire, out_fire;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_EMPTY;
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            main_data_q  <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            skid_data_q  <= '0;
            bub_q        <= '0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            main_data_q  <= main_data_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_data_q  <= skid_data_d;
            bub_q        <= bub_d;
            rdy_en_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        main_data_d  = main_data_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            state_d      = S_EMPTY;
            main_pc_d    = '0;
            main_instr_d = NOP_INSTR;
            main_data_d  = '0;
            skid_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
            skid_data_d  = '0;
        end else if (!stall) begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        if (nop) begin
                            main_pc_d    = '0;
                            main_instr_d = NOP_INSTR;
                            main_data_d  = '0;
                        end else begin
                            main_pc_d    = in_pc;
                            main_instr_d = in_instr;
                            main_data_d  = in_data;
                            state_d      = S_ONE;
                        end
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        if (nop) begin
                            main_pc_d    = '0;
                            main_instr_d = NOP_INSTR;
                            main_data_d  = '0;
                            state_d      = S_EMPTY;
                        end else begin
                            main_pc_d    = in_pc;
                            main_instr_d = in_instr;
                            main_data_d  = in_data;
                        end
                    end else if (in_fire) begin
                        // a killed beat is simply not parked; main keeps its beat
                        if (!nop && SKID != 0) begin
                            skid_pc_d    = in_pc;
                            skid_instr_d = in_instr;
                            skid_data_d  = in_data;
                            state_d      = S_FULL;
                        end
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                        main_data_d  = skid_data_q;
                        state_d      = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid  = (state_q != S_EMPTY);
        skid_valid = (state_q == S_FULL);
        if (SKID != 0) can_take = ~skid_valid;
        else           can_take = ~out_valid | out_ready;
        // rdy_en_q holds off acceptance until the first edge after reset release
        in_ready   = rdy_en_q & (flush | (~stall & can_take));
        in_fire    = in_valid & in_ready;
        out_fire   = out_valid & out_ready & ~stall;
        out_pc     = main_pc_q;
        out_data   = main_data_q;
        out_instr  = out_valid ? main_instr_q : NOP_INSTR;
        bub_d      = (!out_valid && (bub_q != {CNT_W{1'b1}})) ? bub_q + CNT_W'(1) : bub_q;
        bubble_cnt = bub_q;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=0, SKID=1 and a 4-bit counter instance
// driven by a linear sequence of hand-computed steps.
module tb_pipe_stage_reg;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] NOPI = 64'h13;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0, stall = 1'b0, nop = 1'b0, iv = 1'b0, ordy = 1'b1;
    logic [63:0] ipc = '0, idat = '0;
    logic [31:0] iins = '0;
    logic        zero = 1'b0, one = 1'b1;
    logic [63:0] zpc = '0, zdat = '0;
    logic [31:0] zins = '0;

    logic        ir0, ov0, ir1, ov1, ir4, ov4;
    logic [63:0] opc0, odat0, opc1, odat1, opc4, odat4;
    logic [31:0] oins0, oins1, oins4;
    logic [31:0] bc0, bc1;
    logic [3:0]  bc4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    pipe_stage_reg #(.SKID(0)) dut0 (
        .clock(clock), .reset(rst), .flush(flush), .stall(stall), .nop(nop),
        .in_valid(iv), .in_ready(ir0), .in_pc(ipc), .in_instr(iins), .in_data(idat),
        .out_valid(ov0), .out_ready(ordy), .out_pc(opc0), .out_instr(oins0),
        .out_data(odat0), .bubble_cnt(bc0));

    pipe_stage_reg #(.SKID(1)) dut1 (
        .clock(clock), .reset(rst), .flush(flush), .stall(stall), .nop(nop),
        .in_valid(iv), .in_ready(ir1), .in_pc(ipc), .in_instr(iins), .in_data(idat),
        .out_valid(ov1), .out_ready(ordy), .out_pc(opc1), .out_instr(oins1),
        .out_data(odat1), .bubble_cnt(bc1));

    pipe_stage_reg #(.SKID(1), .CNT_W(4)) dut4 (
        .clock(clock), .reset(rst), .flush(zero), .stall(zero), .nop(zero),
        .in_valid(zero), .in_ready(ir4), .in_pc(zpc), .in_instr(zins), .in_data(zdat),
        .out_valid(ov4), .out_ready(one), .out_pc(opc4), .out_instr(oins4),
        .out_data(odat4), .bubble_cnt(bc4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic beat(input logic v, input logic [63:0] pc);
        iv   = v;
        ipc  = pc;
        iins = pc[31:0] ^ 32'h5a5a_0000;
        idat = ~pc;
    endtask

    initial begin
        // reset asserted from time 0
        #3;
        chk("rst_ov1", 64'(ov1), 64'd0);
        chk("rst_ir1", 64'(ir1), 64'd0);
        chk("rst_ir0", 64'(ir0), 64'd0);
        chk("rst_ins1", 64'(oins1), NOPI);
        chk("rst_pc1", opc1, 64'd0);
        chk("rst_bc1", 64'(bc1), 64'd0);
        #4 rst = 1'b1;
        tick();

        // back-to-back streaming, both modes
        for (int k = 0; k < 10; k++) begin
            beat(1'b1, BASE + 64'(4 * k));
            #1;
            chk("str_ir0", 64'(ir0), 64'd1);
            chk("str_ir1", 64'(ir1), 64'd1);
            tick();
            chk("str_ov0", 64'(ov0), 64'd1);
            chk("str_pc0", opc0, BASE + 64'(4 * k));
            chk("str_ov1", 64'(ov1), 64'd1);
            chk("str_pc1", opc1, BASE + 64'(4 * k));
            chk("str_ins1", 64'(oins1), 64'((BASE[31:0] + 32'(4 * k)) ^ 32'h5a5a_0000));
            chk("str_dat1", odat1, ~(BASE + 64'(4 * k)));
            chk("str_bc0", 64'(bc0), 64'd2);
            chk("str_bc1", 64'(bc1), 64'd2);
        end
        beat(1'b0, 64'd0);
        tick();
        chk("drain_ov0", 64'(ov0), 64'd0);
        chk("drain_ov1", 64'(ov1), 64'd0);
        chk("drain_ins1", 64'(oins1), NOPI);
        chk("drain_bc1", 64'(bc1), 64'd2);

        // backpressure on the skid instance
        beat(1'b1, 64'hA0); ordy = 1'b1; tick();
        chk("bp_pcA", opc1, 64'hA0);
        beat(1'b1, 64'hB0); ordy = 1'b0; #1;
        chk("bp_ir_one", 64'(ir1), 64'd1);
        tick();
        chk("bp_full_pc", opc1, 64'hA0);
        beat(1'b1, 64'hC0); #1;
        chk("bp_ir_full1", 64'(ir1), 64'd0);
        tick();
        chk("bp_hold1", opc1, 64'hA0);
        #1;
        chk("bp_ir_full2", 64'(ir1), 64'd0);
        tick();
        chk("bp_hold2", opc1, 64'hA0);
        ordy = 1'b1; #1;
        chk("bp_ir_full3", 64'(ir1), 64'd0);
        tick();
        chk("bp_pcB", opc1, 64'hB0);
        #1;
        chk("bp_ir_one2", 64'(ir1), 64'd1);
        tick();
        chk("bp_pcC", opc1, 64'hC0);
        chk("bp_insC", 64'(oins1), 64'(32'hC0 ^ 32'h5a5a_0000));
        beat(1'b0, 64'd0); tick();
        chk("bp_empty", 64'(ov1), 64'd0);
        chk("bp_bc1", 64'(bc1), 64'd3);

        // stall then nop
        beat(1'b1, 64'hD0); tick();
        chk("st_pcD", opc1, 64'hD0);
        stall = 1'b1; beat(1'b1, 64'hE0); #1;
        chk("st_ir1", 64'(ir1), 64'd0);
        chk("st_ir0", 64'(ir0), 64'd0);
        tick();
        chk("st_ov1a", 64'(ov1), 64'd1);
        chk("st_pc1a", opc1, 64'hD0);
        tick();
        chk("st_ov1b", 64'(ov1), 64'd1);
        chk("st_pc1b", opc1, 64'hD0);
        stall = 1'b0; nop = 1'b1; #1;
        chk("nop_ir1", 64'(ir1), 64'd1);
        tick();
        chk("nop_ov1", 64'(ov1), 64'd0);
        chk("nop_ins1", 64'(oins1), NOPI);
        chk("nop_pc1", opc1, 64'd0);
        chk("nop_ov0", 64'(ov0), 64'd0);
        chk("nop_ins0", 64'(oins0), NOPI);
        chk("nop_pc0", opc0, 64'd0);
        chk("nop_bc1", 64'(bc1), 64'd4);

        // flush while FULL with an incoming beat
        nop = 1'b0; beat(1'b1, 64'hF0); ordy = 1'b0; tick();
        beat(1'b1, 64'h100); tick();
        chk("fl_full_ov", 64'(ov1), 64'd1);
        flush = 1'b1; beat(1'b1, 64'h110); #1;
        chk("fl_ir1", 64'(ir1), 64'd1);
        tick();
        chk("fl_ov1", 64'(ov1), 64'd0);
        chk("fl_ins1", 64'(oins1), NOPI);
        chk("fl_pc1", opc1, 64'd0);
        flush = 1'b0; beat(1'b0, 64'd0); ordy = 1'b1; tick();
        chk("fl_lost", 64'(ov1), 64'd0);
        chk("fl_bc1", 64'(bc1), 64'd6);
        beat(1'b1, 64'h120); tick();
        chk("fl_next_pc", opc1, 64'h120);
        beat(1'b0, 64'd0); tick();
        chk("fl_no_ghost", 64'(ov1), 64'd0);

        // asynchronous reset mid-stream
        beat(1'b1, 64'h130); tick();
        chk("mr_pre_ov", 64'(ov1), 64'd1);
        chk("cnt4_sat_pre", 64'(bc4), 64'd15);
        #2 rst = 1'b0;
        #1;
        chk("mr_ov1", 64'(ov1), 64'd0);
        chk("mr_bc1", 64'(bc1), 64'd0);
        chk("mr_bc4", 64'(bc4), 64'd0);
        chk("mr_ir1", 64'(ir1), 64'd0);
        chk("mr_ins1", 64'(oins1), NOPI);
        #1 rst = 1'b1;
        beat(1'b1, 64'h140);
        tick();
        chk("rel_ov1", 64'(ov1), 64'd0);
        chk("rel_bc4", 64'(bc4), 64'd1);
        #1;
        chk("rel_ir1", 64'(ir1), 64'd1);
        tick();
        chk("rel_ov1b", 64'(ov1), 64'd1);
        chk("rel_pc1", opc1, 64'h140);
        chk("rel_bc1", 64'(bc1), 64'd2);
        beat(1'b0, 64'd0); tick();

        // idle run: 32-bit counter keeps counting, 4-bit counter saturates
        repeat (20) tick();
        chk("idle_bc1", 64'(bc1), 64'd22);
        chk("cnt4_sat", 64'(bc4), 64'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
